// File: rtl/terrain_dig_arbiter.sv
// terrain_dig_arbiter
// Arbitrates terrain dig requests from the player (index 0) and monsters
// (indices 1..NREQ-1) into a single terrain write port. Writes are only
// arbitrated during a write window of WIN_LEN cycles opened by startOfFrame.
// Optional feature macro: DIG_PLAYER_PRIO_EN (player wins whenever eligible,
// monsters share the round-robin among indices 1..NREQ-1).
`timescale 1ns/1ps
module terrain_dig_arbiter #(
  parameter int NREQ    = 4,
  parameter int XW      = 6,
  parameter int YW      = 5,
  parameter int WIN_LEN = 64
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*XW-1:0]   req_x,
  input  logic [NREQ*YW-1:0]   req_y,
  output logic [NREQ-1:0]      gnt,
  output logic                 wr_en,
  output logic [XW-1:0]        wr_x,
  output logic [YW-1:0]        wr_y,
  output logic                 window_open
);

  localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [9:0] CNT_LOAD = 10'(WIN_LEN - 1);

  typedef enum logic {IDLE, WINDOW} state_t;

  state_t          state_reg, state_next;
  logic [9:0]      cnt_reg, cnt_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic            wr_en_reg, wr_en_next;
  logic [XW-1:0]   wr_x_reg, wr_x_next;
  logic [YW-1:0]   wr_y_reg, wr_y_next;

  logic [NREQ-1:0] elig;
  logic            sel_found;
  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   cand_idx;
  int              cand;

  // Window FSM: IDLE waits for startOfFrame, WINDOW counts down to 0.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (startOfFrame) begin
          state_next = WINDOW;
          cnt_next   = CNT_LOAD;
        end
      end
      WINDOW: begin
        if (startOfFrame) begin
          cnt_next = CNT_LOAD;
        end else if (cnt_reg == 10'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 10'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Round-robin selection starting after the last granted index; a requester
  // granted last cycle is masked so it cannot win twice in a row.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    elig      = (state_reg == WINDOW) ? (req & ~gnt_reg) : '0;
`ifdef DIG_PLAYER_PRIO_EN
    if (elig[0]) begin
      sel_found = 1'b1;
      sel_idx   = '0;
    end
`endif
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = PW'(cand);
`ifdef DIG_PLAYER_PRIO_EN
      if (!sel_found && (cand != 0) && elig[cand_idx]) begin
`else
      if (!sel_found && elig[cand_idx]) begin
`endif
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // Next values of the registered grant and terrain write port.
  always_comb begin
    gnt_next   = '0;
    wr_en_next = 1'b0;
    wr_x_next  = '0;
    wr_y_next  = '0;
    ptr_next   = ptr_reg;
    if (sel_found) begin
      gnt_next[sel_idx] = 1'b1;
      wr_en_next        = 1'b1;
      wr_x_next         = req_x[sel_idx*XW +: XW];
      wr_y_next         = req_y[sel_idx*YW +: YW];
`ifdef DIG_PLAYER_PRIO_EN
      // The player bypasses the monster rotation, so it leaves the pointer alone.
      if (sel_idx != '0) ptr_next = sel_idx;
`else
      ptr_next = sel_idx;
`endif
    end
  end

  // State, counter, pointer and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= '0;
      gnt_reg   <= '0;
      wr_en_reg <= 1'b0;
      wr_x_reg  <= '0;
      wr_y_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      wr_en_reg <= wr_en_next;
      wr_x_reg  <= wr_x_next;
      wr_y_reg  <= wr_y_next;
    end
  end

  assign gnt         = gnt_reg;
  assign wr_en       = wr_en_reg;
  assign wr_x        = wr_x_reg;
  assign wr_y        = wr_y_reg;
  assign window_open = (state_reg == WINDOW);

endmodule

// File: tb/tb_terrain_dig_arbiter.sv
// Self-checking bench for terrain_dig_arbiter: a cycle model pushes the
// expected outputs of every clock edge into a scoreboard queue, which is
// popped and compared just after the edge; directed checks cover window
// length, grant order, back-to-back masking, window end and reset.
`timescale 1ns/1ps
module tb_terrain_dig_arbiter;

  localparam int NREQ    = 4;
  localparam int XW      = 6;
  localparam int YW      = 5;
  localparam int WIN_LEN = 64;

  logic                clk = 1'b0;
  logic                resetN = 1'b0;
  logic                startOfFrame = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*XW-1:0]  req_x;
  logic [NREQ*YW-1:0]  req_y;
  logic [NREQ-1:0]     gnt;
  logic                wr_en;
  logic [XW-1:0]       wr_x;
  logic [YW-1:0]       wr_y;
  logic                window_open;

  terrain_dig_arbiter #(.NREQ(NREQ), .XW(XW), .YW(YW), .WIN_LEN(WIN_LEN)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .req(req), .req_x(req_x), .req_y(req_y),
    .gnt(gnt), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .window_open(window_open)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic            wr_en;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            win;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  logic            m_win = 1'b0;
  int              m_cnt = 0;
  int              m_ptr = 0;
  logic [NREQ-1:0] m_gnt = '0;
  logic [NREQ-1:0] drop_mask = '1;

  // observation logs
  int   grant_log[$];
  int   x_log[$];
  int   y_log[$];
  int   win_cycles = 0;
  logic prev_g2 = 1'b0;
  int   consec2 = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Predicts the outputs right after the coming edge from the sampled inputs.
  task automatic model_step();
    exp_t            e;
    logic [NREQ-1:0] el;
    int              sel;
    int              c;
    e   = '0;
    sel = -1;
    if (!resetN) begin
      m_win = 1'b0; m_cnt = 0; m_ptr = 0; m_gnt = '0;
      sb_q.push_back(e);
      return;
    end
    if (m_win) begin
      el = req & ~m_gnt;
`ifdef DIG_PLAYER_PRIO_EN
      if (el[0]) sel = 0;
`endif
      for (int k = 1; k <= NREQ && sel < 0; k++) begin
        c = (m_ptr + k) % NREQ;
`ifdef DIG_PLAYER_PRIO_EN
        if (el[c] && c != 0) sel = c;
`else
        if (el[c]) sel = c;
`endif
      end
    end
    if (sel >= 0) begin
      e.gnt[sel] = 1'b1;
      e.wr_en    = 1'b1;
      e.x        = req_x[sel*XW +: XW];
      e.y        = req_y[sel*YW +: YW];
`ifdef DIG_PLAYER_PRIO_EN
      if (sel != 0) m_ptr = sel;
`else
      m_ptr = sel;
`endif
    end
    if (!m_win) begin
      if (startOfFrame) begin m_win = 1'b1; m_cnt = WIN_LEN - 1; end
    end else if (startOfFrame) begin
      m_cnt = WIN_LEN - 1;
    end else if (m_cnt == 0) begin
      m_win = 1'b0;
    end else begin
      m_cnt--;
    end
    e.win = m_win;
    m_gnt = e.gnt;
    sb_q.push_back(e);
  endtask

  // One clock cycle: predict, compare after the edge, then requesters react.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    e = sb_q.pop_front();
    check_val("cycle", {gnt, wr_en, wr_x, wr_y, window_open}, e);
    for (int i = 0; i < NREQ; i++) if (gnt[i]) grant_log.push_back(i);
    if (wr_en) begin x_log.push_back(int'(wr_x)); y_log.push_back(int'(wr_y)); end
    if (window_open) win_cycles++;
    if (gnt[2] && prev_g2) consec2++;
    prev_g2 = gnt[2];
    @(negedge clk);
    req = req & ~(m_gnt & drop_mask);
  endtask

  task automatic clear_logs();
    grant_log.delete(); x_log.delete(); y_log.delete();
    win_cycles = 0; consec2 = 0;
  endtask

  task automatic pulse_sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && window_open; i++) tick();
    check_val("idle_reached", window_open, 1'b0);
  endtask

  function automatic int count_idx(input int idx);
    int n = 0;
    foreach (grant_log[i]) if (grant_log[i] == idx) n++;
    return n;
  endfunction

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*XW +: XW] = (i == 0) ? XW'(3) : XW'(10 + i);
      req_y[i*YW +: YW] = (i == 0) ? YW'(7) : YW'(20 + i);
    end

    // reset state
    tick(); tick();
    check_val("rst_gnt", gnt, 0);
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_wr_x", wr_x, 0);
    check_val("rst_wr_y", wr_y, 0);
    check_val("rst_window", window_open, 0);
    resetN = 1'b1;

    // requests without a window are held, never granted
    clear_logs();
    req = 4'b0001;
    repeat (100) tick();
    check_val("idle_grants", grant_log.size(), 0);
    check_val("idle_window", win_cycles, 0);
    req = '0;

    // window length
    clear_logs();
    pulse_sof();
    repeat (80) tick();
    check_val("window_len", win_cycles, WIN_LEN);

    // leave the pointer at 3, then all four request together
    pulse_sof();
    req = 4'b1000;
    repeat (3) tick();
    clear_logs();
    req = 4'b1111;
    repeat (6) tick();
    check_val("rr_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check_val("rr_order", (i < grant_log.size()) ? grant_log[i] : -1, i);
    check_val("first_wr_x", (x_log.size() > 0) ? x_log[0] : -1, 3);
    check_val("first_wr_y", (y_log.size() > 0) ? y_log[0] : -1, 7);

    // a requester that never drops is granted every other cycle
    clear_logs();
    drop_mask = 4'b1011;
    req = 4'b0100;
    repeat (20) tick();
    check_val("g2_back_to_back", consec2, 0);
    check_val("g2_count", count_idx(2), 10);
    req = '0;
    drop_mask = '1;
    tick();

    // two requests arriving in the last window cycle
    wait_idle();
    pulse_sof();
    repeat (WIN_LEN - 1) tick();
    clear_logs();
    req = 4'b0110;
    tick();
    check_val("last_cycle_grant_win", window_open, 0);
    repeat (10) tick();
    check_val("last_cycle_grants", grant_log.size(), 1);
    check_val("last_cycle_idx", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    pulse_sof();
    repeat (3) tick();
    check_val("next_frame_grants", grant_log.size(), 2);
    check_val("next_frame_idx", (grant_log.size() > 1) ? grant_log[1] : -1, 2);

    // reset in the middle of a window with requests active
    drop_mask = '0;
    req = 4'b1100;
    repeat (3) tick();
    resetN = 1'b0;
    #1;
    check_val("mid_rst_gnt", gnt, 0);
    check_val("mid_rst_wr_en", wr_en, 0);
    check_val("mid_rst_wr_x", wr_x, 0);
    check_val("mid_rst_wr_y", wr_y, 0);
    check_val("mid_rst_window", window_open, 0);
    tick();
    resetN = 1'b1;
    clear_logs();
    drop_mask = '1;
    req = 4'b0110;
    repeat (10) tick();
    check_val("post_rst_no_grant", grant_log.size(), 0);
    pulse_sof();
    repeat (2) tick();
    check_val("post_rst_first_idx", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    req = '0;
    tick();

`ifdef DIG_PLAYER_PRIO_EN
    // player re-requesting every other cycle wins each eligible cycle
    wait_idle();
    pulse_sof();
    clear_logs();
    req = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      req[0] = 1'b1;
      tick();
      tick();
    end
    check_val("prio_player_wins", count_idx(0), 8);
    req = '0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/terrain_dig_arbiter.md
TERRAIN_DIG_ARBITER -- requirements
Module: terrain_dig_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of dig requesters; index 0 is the player, 1..NREQ-1 are monsters.
REQ-002 Parameter XW, default 6: cell X coordinate width.
REQ-003 Parameter YW, default 5: cell Y coordinate width.
REQ-004 Parameter WIN_LEN, default 64: write-window length in clock cycles, legal range 1..1023.
REQ-005 clk  input  1  pixel clock; all state SHALL update on its rising edge.
REQ-006 resetN  input  1  asynchronous active-low reset.
REQ-007 startOfFrame  input  1  one-cycle pulse at frame start; opens the write window.
REQ-008 req  input  NREQ  per-requester dig request; level, held until granted.
REQ-009 req_x  input  NREQ*XW  packed cell X per requester; slice i = bits [i*XW +: XW].
REQ-010 req_y  input  NREQ*YW  packed cell Y per requester; same packing as req_x.
REQ-011 gnt  output  NREQ  one-hot, one-cycle grant pulse.
REQ-012 wr_en  output  1  terrain write strobe; clears the addressed cell.
REQ-013 wr_x  output  XW  terrain write cell X.
REQ-014 wr_y  output  YW  terrain write cell Y.
REQ-015 window_open  output  1  high while in state WINDOW.

Function
REQ-016 The FSM SHALL have two states: IDLE and WINDOW.
REQ-017 In IDLE, startOfFrame=1 SHALL move the FSM to WINDOW and load the window counter with WIN_LEN-1.
REQ-018 In WINDOW, the counter SHALL decrement each cycle; the cycle it reads 0 is the last window cycle, after which the FSM returns to IDLE.
REQ-019 startOfFrame in WINDOW SHALL reload the counter to WIN_LEN-1 and keep the FSM in WINDOW.
REQ-020 Arbitration SHALL occur only in cycles where the FSM is in WINDOW; requests in IDLE are held pending, never dropped.
REQ-021 At most one requester SHALL be granted per cycle; a requester granted in cycle t SHALL be ineligible in cycle t+1.
REQ-022 Selection SHALL be round-robin: the search starts at the index after the last granted index and wraps from NREQ-1 to 0; the pointer resets to 0.
REQ-023 The grant for a request sampled in cycle t SHALL appear, registered, in cycle t+1: gnt[i]=1, wr_en=1, wr_x/wr_y = the slice i values sampled in cycle t.
REQ-024 A requester SHALL deassert req in the cycle it observes gnt; the arbiter does not check compliance beyond REQ-021.
REQ-025 When wr_en=0, wr_x and wr_y SHALL be 0.
REQ-026 Identical cells requested in the same cycle SHALL be granted in turn; duplicate writes are permitted.
REQ-027 A grant decided in the last window cycle SHALL still be issued in the following cycle, even though window_open is then 0.

Reset
REQ-028 resetN=0 SHALL asynchronously force: FSM to IDLE, counter to 0, pointer to 0, gnt=0, wr_en=0, wr_x=0, wr_y=0, window_open=0.
REQ-029 Reset mid-window SHALL abort the window; pending requests are re-arbitrated only after the next startOfFrame.

Configuration
REQ-030 Macro DIG_PLAYER_PRIO_EN defined: requester 0 SHALL win whenever eligible; round-robin applies to indices 1..NREQ-1 only.
REQ-031 Macro DIG_PLAYER_PRIO_EN undefined: all NREQ requesters SHALL share one round-robin per REQ-022.

Verification
REQ-032 Reset released, no startOfFrame, req=4'b0001 held for 100 cycles -> gnt=0, wr_en=0, window_open=0 throughout.
REQ-033 startOfFrame pulse, WIN_LEN=64 -> window_open high for exactly 64 cycles, then 0.
REQ-034 Window open, req=4'b1111, each req dropped on its gnt, player at (3,7) -> grants in order 0,1,2,3 on consecutive cycles, first grant wr_x=3, wr_y=7. With DIG_PLAYER_PRIO_EN and player re-requesting every other cycle -> player wins every eligible cycle.
REQ-035 req[2] held constantly and never dropped -> gnt[2] pulses no more often than every other cycle.
REQ-036 req=4'b0110 asserted in the last window cycle -> one grant issued in the next cycle; the other is granted only after the next startOfFrame.
REQ-037 resetN pulsed low mid-window with req active -> all outputs 0 immediately; no grant until the next startOfFrame; the first grant then goes to index 1 (pointer reset to 0, search starts at index 1).
